queue_ctrl: RTL and testbench

Sequencing controller between the serial deserializer and the 8-entry byte queue inside `top`. It accepts completed bytes from the deserializer and issues enqueue strobes only when the queue has room. It also shares the queue's read port between two consumers using round-robin dequeue arbitration. It drives the deserializer's ready/status line, so serial senders are throttled when the queue and the one-byte holding register are both full.

---
 rtl/queue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_queue_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_ctrl.sv
// Sequencing controller between the byte deserializer and the 8-entry byte queue: one-byte holding
// register, enqueue throttling and round-robin shared dequeue. Optional drop counter: QUEUE_CTRL_DROP_CNT_EN.
module queue_ctrl #(
    parameter int QUEUE_DEPTH = 8,
    parameter int LEN_W       = 4,
    parameter int DEQ_LAT     = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             deser_valid_in,
    input  logic [7:0]       deser_data_in,
    output logic             deser_ready_out,
    output logic             enq_out,
    output logic [7:0]       enq_data_out,
    input  logic [LEN_W-1:0] q_len_in,
    output logic             deq_out,
    input  logic [7:0]       q_data_in,
    input  logic [1:0]       req_in,
    output logic [1:0]       gnt_out,
    output logic             rd_valid_out,
    output logic [7:0]       rd_data_out,
    output logic [7:0]       drop_cnt_out
);

    localparam logic [LEN_W:0] DEPTH_L  = (LEN_W + 1)'(QUEUE_DEPTH);
    localparam logic [1:0]     LAT_LAST = 2'(DEQ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        last_gnt_q, last_gnt_d;
    logic        deq_q, deq_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_v_q, hold_v_d;
    logic        enq_q, enq_d;
    logic [7:0]  enq_data_q, enq_data_d;
    logic        ready_q, ready_d;

    logic [LEN_W:0] eff_len;
    logic [LEN_W:0] eff_next;
    logic           full;
    logic           empty;
    logic           accept;

    // Occupancy as the queue will see it once the strobes now on the bus have landed.
    assign eff_len = {1'b0, q_len_in} + {{LEN_W{1'b0}}, enq_q} - {{LEN_W{1'b0}}, deq_q};
    assign full    = (eff_len >= DEPTH_L);
    assign empty   = (eff_len == '0);
    assign accept  = deser_valid_in & ready_q;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        deq_d       = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        case (state_q)
            IDLE: begin
                if ((req_in != 2'b00) && !empty) begin
                    state_d = ISSUE;
                    deq_d   = 1'b1;
                    if (req_in == 2'b11) begin
                        gnt_d = last_gnt_q ? 2'b01 : 2'b10;
                    end else begin
                        gnt_d = req_in;
                    end
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                wait_cnt_d = 2'd0;
            end
            WAIT: begin
                if (wait_cnt_q == LAT_LAST) begin
                    rd_data_d  = q_data_in;
                    rd_valid_d = 1'b1;
                    state_d    = DELIVER;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            DELIVER: begin
                last_gnt_d = gnt_q[1];
                gnt_d      = 2'b00;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The held byte always goes first; a same-cycle arrival takes its place in the holding register.
    always_comb begin
        enq_d      = 1'b0;
        enq_data_d = enq_data_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        if (hold_v_q) begin
            if (!full) begin
                enq_d      = 1'b1;
                enq_data_d = hold_q;
                hold_v_d   = 1'b0;
                if (accept) begin
                    hold_d   = deser_data_in;
                    hold_v_d = 1'b1;
                end
            end
        end else if (accept) begin
            if (!full) begin
                enq_d      = 1'b1;
                enq_data_d = deser_data_in;
            end else begin
                hold_d   = deser_data_in;
                hold_v_d = 1'b1;
            end
        end
    end

    // Ready is precomputed from next-cycle occupancy so the flop always matches !hold_v | !full.
    always_comb begin
        eff_next = eff_len + {{LEN_W{1'b0}}, enq_d} - {{LEN_W{1'b0}}, deq_d};
        ready_d  = !hold_v_d || (eff_next < DEPTH_L);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 2'd0;
            gnt_q      <= 2'b00;
            last_gnt_q <= 1'b1;
            deq_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            hold_q     <= 8'h00;
            hold_v_q   <= 1'b0;
            enq_q      <= 1'b0;
            enq_data_q <= 8'h00;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            deq_q      <= deq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            enq_q      <= enq_d;
            enq_data_q <= enq_data_d;
            ready_q    <= ready_d;
        end
    end

`ifdef QUEUE_CTRL_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (deser_valid_in && !ready_q && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_out = drop_cnt_q;
`else
    assign drop_cnt_out = 8'h00;
`endif

    assign deser_ready_out = ready_q;
    assign enq_out         = enq_q;
    assign enq_data_out    = enq_data_q;
    assign deq_out         = deq_q;
    assign gnt_out         = gnt_q;
    assign rd_valid_out    = rd_valid_q;
    assign rd_data_out     = rd_data_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl with a behavioural 8-entry queue of DEQ_LAT read latency.
module tb_queue_ctrl;

    localparam int QUEUE_DEPTH = 8;
    localparam int LEN_W       = 4;
    localparam int DEQ_LAT     = 1;
    localparam int EXP_DROP    =
`ifdef QUEUE_CTRL_DROP_CNT_EN
        1;
`else
        0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             deser_valid_in = 1'b0;
    logic [7:0]       deser_data_in = 8'h00;
    logic             deser_ready_out;
    logic             enq_out;
    logic [7:0]       enq_data_out;
    logic [LEN_W-1:0] q_len_in;
    logic             deq_out;
    logic [7:0]       q_data_in;
    logic [1:0]       req_in = 2'b00;
    logic [1:0]       gnt_out;
    logic             rd_valid_out;
    logic [7:0]       rd_data_out;
    logic [7:0]       drop_cnt_out;

    always #5 clock = ~clock;

    queue_ctrl #(.QUEUE_DEPTH(QUEUE_DEPTH), .LEN_W(LEN_W), .DEQ_LAT(DEQ_LAT)) dut (
        .clock(clock), .reset(reset),
        .deser_valid_in(deser_valid_in), .deser_data_in(deser_data_in),
        .deser_ready_out(deser_ready_out),
        .enq_out(enq_out), .enq_data_out(enq_data_out), .q_len_in(q_len_in),
        .deq_out(deq_out), .q_data_in(q_data_in),
        .req_in(req_in), .gnt_out(gnt_out),
        .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
        .drop_cnt_out(drop_cnt_out)
    );

    // Behavioural queue: length updates the cycle after a strobe, head byte DEQ_LAT cycles after deq.
    logic [7:0] qmem [0:15];
    logic [7:0] qpipe [0:2];
    int q_wr, q_rd, q_cnt;
    int ovf_n = 0;
    int unf_n = 0;

    assign q_len_in  = LEN_W'(q_cnt);
    assign q_data_in = qpipe[DEQ_LAT-1];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_wr <= 0; q_rd <= 0; q_cnt <= 0;
            qpipe[0] <= 8'h00; qpipe[1] <= 8'h00; qpipe[2] <= 8'h00;
        end else begin
            if (enq_out) begin
                qmem[q_wr % 16] <= enq_data_out;
                q_wr <= q_wr + 1;
                if (!deq_out && q_cnt >= QUEUE_DEPTH) ovf_n <= ovf_n + 1;
            end
            if (deq_out) begin
                q_rd <= q_rd + 1;
                if (q_cnt == 0) unf_n <= unf_n + 1;
            end
            qpipe[0] <= deq_out ? qmem[q_rd % 16] : 8'h00;
            qpipe[1] <= qpipe[0];
            qpipe[2] <= qpipe[1];
            q_cnt <= q_cnt + (enq_out ? 1 : 0) - (deq_out ? 1 : 0);
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] enq_log [0:63];
    logic [7:0] rdd [0:31];
    logic [1:0] rdg [0:31];
    int rdc [0:31];
    int deq_c [0:31];
    int enq_n = 0;
    int rd_n  = 0;
    int deq_n = 0;

    always @(negedge clock) begin
        if (enq_out && enq_n < 64) begin
            enq_log[enq_n] = enq_data_out;
            enq_n++;
        end
        if (deq_out && deq_n < 32) begin
            deq_c[deq_n] = cyc;
            deq_n++;
        end
        if (rd_valid_out && rd_n < 32) begin
            rdd[rd_n] = rd_data_out;
            rdg[rd_n] = gnt_out;
            rdc[rd_n] = cyc;
            rd_n++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        deser_valid_in = 1'b1;
        deser_data_in  = b;
        tick(1);
        deser_valid_in = 1'b0;
    endtask

    task automatic wait_rd(input int target, input string tag);
        int k;
        k = 0;
        while (rd_n < target && k < 200) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(rd_n), 32'(target));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(deser_ready_out), 1);
        chk({tag, "_strobes"}, 32'({enq_out, deq_out, rd_valid_out, gnt_out}), 0);
        chk({tag, "_data"}, 32'({enq_data_out, rd_data_out, drop_cnt_out}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cyc, base_rd, base_enq, base_deq, k;

        // Reset values
        tick(3);
        chk_reset_outs("rst");
        reset = 1'b1;
        tick(2);

        // Fill the queue with 0x80..0x87, no readers
        for (int i = 0; i < 8; i++) begin
            chk("p1_ready", 32'(deser_ready_out), 1);
            send_byte(8'h80 + 8'(i));
        end
        tick(3);
        chk("p1_enq_n", 32'(enq_n), 8);
        for (int i = 0; i < 8; i++) chk("p1_enq_data", 32'(enq_log[i]), 32'h80 + 32'(i));
        chk("p1_ready_end", 32'(deser_ready_out), 1);

        // Queue full: 0x88 parks in the holding register
        chk("p2_ready_pre", 32'(deser_ready_out), 1);
        send_byte(8'h88);
        chk("p2_ready_low", 32'(deser_ready_out), 0);
        tick(2);
        chk("p2_no_enq", 32'(enq_n), 8);

        // Full plus held: 0x89 is dropped
        send_byte(8'h89);
        tick(1);
        chk("p3_drop_cnt", 32'(drop_cnt_out), 32'(EXP_DROP));
        chk("p3_ready_low", 32'(deser_ready_out), 0);

        // Requester 0 reads 0x80; the held byte then drains
        req_in = 2'b01;
        req_cyc = cyc;
        wait_rd(1, "p2_rd_done");
        req_in = 2'b00;
        chk("p2_rd_data", 32'(rdd[0]), 32'h80);
        chk("p2_rd_gnt", 32'(rdg[0]), 1);
        chk("p2_deq2rd", 32'(rdc[0] - deq_c[0]), 32'(DEQ_LAT + 1));
        chk("p2_req2rd", 32'(rdc[0] - req_cyc + 1), 32'(3 + DEQ_LAT));
        tick(3);
        chk("p2_enq_n", 32'(enq_n), 9);
        chk("p2_enq_held", 32'(enq_log[8]), 32'h88);
        chk("p2_ready_high", 32'(deser_ready_out), 1);
        chk("p2_qlen", 32'(q_cnt), 8);

        // Fresh reset, 4 bytes, both requesters held
        reset = 1'b0;
        #1;
        chk("p4_drop_clr", 32'(drop_cnt_out), 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        base_enq = enq_n;
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        tick(3);
        chk("p4_enq_n", 32'(enq_n - base_enq), 4);
        base_rd = rd_n;
        req_in = 2'b11;
        wait_rd(base_rd + 4, "p4_rd_done");
        req_in = 2'b00;
        for (int j = 0; j < 4; j++) begin
            chk("p4_rd_data", 32'(rdd[base_rd + j]), 32'h10 + 32'(j));
            chk("p4_rd_gnt", 32'(rdg[base_rd + j]), (j % 2 == 0) ? 32'd1 : 32'd2);
            chk("p4_deq2rd", 32'(rdc[base_rd + j] - deq_c[base_rd + j]), 32'(DEQ_LAT + 1));
            if (j > 0) chk("p4_b2b_gap", 32'(rdc[base_rd + j] - rdc[base_rd + j - 1]), 32'(3 + DEQ_LAT));
        end

        // Empty queue with requester 1 waiting
        tick(2);
        base_deq = deq_n;
        base_rd = rd_n;
        req_in = 2'b10;
        tick(10);
        chk("p5_no_deq", 32'(deq_n), 32'(base_deq));
        chk("p5_no_gnt", 32'(gnt_out), 0);
        send_byte(8'h42);
        wait_rd(base_rd + 1, "p5_rd_done");
        req_in = 2'b00;
        chk("p5_rd_data", 32'(rdd[base_rd]), 32'h42);
        chk("p5_rd_gnt", 32'(rdg[base_rd]), 2);

        // Reset pulsed while the read is in WAIT
        tick(2);
        send_byte(8'h55);
        tick(2);
        base_rd = rd_n;
        req_in = 2'b01;
        k = 0;
        while (!deq_out && k < 20) begin
            tick(1);
            k++;
        end
        chk("p6_deq_seen", 32'(deq_out), 1);
        tick(1);
        chk("p6_gnt_wait", 32'(gnt_out), 1);
        reset = 1'b0;
        #1;
        chk_reset_outs("p6_rst");
        req_in = 2'b00;
        tick(2);
        reset = 1'b1;
        tick(10);
        chk("p6_no_rd", 32'(rd_n), 32'(base_rd));

        chk("q_overflow", 32'(ovf_n), 0);
        chk("q_underflow", 32'(unf_n), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
